// File: rtl/network_interface.sv
// Per-node network interface: packetises PE requests into 17-bit flits for the router's local
// port and buffers flits delivered by the router in an RX FIFO for the PE.
module network_interface #(
  parameter logic [3:0]  NODE_ID  = 4'hF,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pe_req_i,
  input  logic [3:0]  pe_dest_i,
  input  logic [2:0]  pe_len_i,
  output logic        pe_req_ack_o,
  input  logic        pe_word_valid_i,
  input  logic [14:0] pe_word_i,
  output logic        pe_word_ready_o,
  output logic        tx_busy_o,
  output logic [16:0] local_data_o,
  input  logic        local_full_i,
  input  logic [16:0] local_data_i,
  output logic        rx_valid_o,
  output logic        rx_head_o,
  output logic [14:0] rx_data_o,
  input  logic        rx_ready_i,
  output logic        rx_overflow_o
);

  localparam int unsigned AW = $clog2(RX_DEPTH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBody = 1'b1;

  // ---------------------------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------------------------
  logic [0:0]  state_q, state_d;
  logic [2:0]  remaining_q, remaining_d;
  logic [16:0] data_q, data_d;
  logic        launch_ok;

  // The valid bit of the registered flit marks a launch on the previous edge, which enforces the
  // one-cycle gap the router needs to update its credit.
  assign launch_ok = ~local_full_i & ~data_q[16];

  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    data_d          = 17'b0;
    pe_req_ack_o    = 1'b0;
    pe_word_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        pe_req_ack_o = rst & pe_req_i & launch_ok;
        if (pe_req_ack_o) begin
          data_d      = {1'b1, 1'b1, pe_dest_i, NODE_ID, pe_len_i, 4'h0};
          remaining_d = pe_len_i;
          state_d     = (pe_len_i == 3'd0) ? StIdle : StBody;
        end
      end
      StBody: begin
        pe_word_ready_o = rst & launch_ok;
        if (pe_word_valid_i && pe_word_ready_o) begin
          data_d      = {1'b1, 1'b0, pe_word_i};
          remaining_d = remaining_q - 3'd1;
          if (remaining_q == 3'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      remaining_q <= 3'd0;
      data_q      <= 17'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  assign tx_busy_o    = (state_q == StBody);
  assign local_data_o = data_q;

  // ---------------------------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------------------------
  logic [15:0]   mem_q [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          full, push, pop, push_acc;

  // RX_DEPTH is a power of two, so the counter MSB alone signals full.
  assign full     = count_q[AW];
  assign push     = local_data_i[16];
  assign pop      = rx_valid_o & rx_ready_i;
  assign push_acc = push & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_acc, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && !push_acc) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= local_data_i[15:0];
  end

  assign rx_valid_o    = (count_q != '0);
  assign rx_head_o     = rx_valid_o & mem_q[rd_ptr_q][15];
  assign rx_data_o     = rx_valid_o ? mem_q[rd_ptr_q][14:0] : 15'b0;
  assign rx_overflow_o = overflow_q;

endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface: stimulus pushes expected TX/RX flits into queues and a
// negedge monitor pops and compares whenever the DUT launches or pops a flit.
module tb_network_interface;

  localparam logic [3:0] NODE = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pe_req_i = 1'b0;
  logic [3:0]  pe_dest_i = 4'h0;
  logic [2:0]  pe_len_i = 3'd0;
  logic        pe_req_ack_o;
  logic        pe_word_valid_i = 1'b0;
  logic [14:0] pe_word_i = 15'h0;
  logic        pe_word_ready_o;
  logic        tx_busy_o;
  logic [16:0] local_data_o;
  logic        local_full_i = 1'b0;
  logic [16:0] local_data_i = 17'h0;
  logic        rx_valid_o;
  logic        rx_head_o;
  logic [14:0] rx_data_o;
  logic        rx_ready_i = 1'b0;
  logic        rx_overflow_o;

  network_interface #(.NODE_ID(NODE), .RX_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .pe_req_i        (pe_req_i),
    .pe_dest_i       (pe_dest_i),
    .pe_len_i        (pe_len_i),
    .pe_req_ack_o    (pe_req_ack_o),
    .pe_word_valid_i (pe_word_valid_i),
    .pe_word_i       (pe_word_i),
    .pe_word_ready_o (pe_word_ready_o),
    .tx_busy_o       (tx_busy_o),
    .local_data_o    (local_data_o),
    .local_full_i    (local_full_i),
    .local_data_i    (local_data_i),
    .rx_valid_o      (rx_valid_o),
    .rx_head_o       (rx_head_o),
    .rx_data_o       (rx_data_o),
    .rx_ready_i      (rx_ready_i),
    .rx_overflow_o   (rx_overflow_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rx_pops = 0;
  logic [16:0] txq[$];
  logic [15:0] rxq[$];
  logic        prev_valid = 1'b0;
  logic        prev_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every launched flit and every RX pop is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      if (local_data_o[16]) begin
        if (txq.size() == 0) check("tx_unexpected", {15'h0, local_data_o}, 32'h0);
        else                 check("tx_flit", {15'h0, local_data_o}, {15'h0, txq.pop_front()});
        check("tx_gap", {31'h0, prev_valid}, 32'h0);
        check("tx_full_respected", {31'h0, prev_full}, 32'h0);
      end else if (local_data_o != 17'h0) begin
        check("tx_idle_zero", {15'h0, local_data_o}, 32'h0);
      end
      if (rx_valid_o && rx_ready_i) begin
        rx_pops <= rx_pops + 1;
        if (rxq.size() == 0) check("rx_unexpected", {16'h0, rx_head_o, rx_data_o}, 32'hDEAD);
        else                 check("rx_flit", {16'h0, rx_head_o, rx_data_o}, {16'h0, rxq.pop_front()});
      end
    end
    prev_valid <= local_data_o[16];
    prev_full  <= local_full_i;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [3:0] d, input logic [2:0] l);
    int w = 0;
    pe_req_i  = 1'b1;
    pe_dest_i = d;
    pe_len_i  = l;
    @(negedge clk);
    while (!pe_req_ack_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("hdr_ack", {31'h0, pe_req_ack_o}, 32'h1);
    txq.push_back({2'b11, d, NODE, l, 4'h0});
    tick();
    pe_req_i = 1'b0;
  endtask

  task automatic send_word(input logic [14:0] wd);
    int w = 0;
    pe_word_valid_i = 1'b1;
    pe_word_i       = wd;
    @(negedge clk);
    while (!pe_word_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("body_ready", {31'h0, pe_word_ready_o}, 32'h1);
    txq.push_back({2'b10, wd});
    tick();
    pe_word_valid_i = 1'b0;
  endtask

  task automatic rx_drive(input logic [15:0] f);
    local_data_i = {1'b1, f};
    tick();
  endtask

  task automatic rx_drain();
    int w = 0;
    rx_ready_i = 1'b1;
    @(negedge clk);
    while (rx_valid_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rx_drain_done", {31'h0, rx_valid_o}, 32'h0);
    rx_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] f;
    // Reset state, with a request pending to confirm ack is suppressed.
    pe_req_i = 1'b1;
    #2;
    check("rst_local_data", {15'h0, local_data_o}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid_o}, 32'h0);
    check("rst_rx_head", {31'h0, rx_head_o}, 32'h0);
    check("rst_rx_data", {17'h0, rx_data_o}, 32'h0);
    check("rst_overflow", {31'h0, rx_overflow_o}, 32'h0);
    check("rst_busy", {31'h0, tx_busy_o}, 32'h0);
    check("rst_ack", {31'h0, pe_req_ack_o}, 32'h0);
    pe_req_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // 1: zero-length packet, header only.
    send_hdr(4'h3, 3'd0);
    check("t1_hdr_value", {15'h0, local_data_o}, 32'h19F80);
    check("t1_busy", {31'h0, tx_busy_o}, 32'h0);
    @(negedge clk);
    check("t1_busy_after", {31'h0, tx_busy_o}, 32'h0);
    tick();

    // 2: two body flits at peak rate; ready alternates with the gap cycle.
    send_hdr(4'h6, 3'd2);
    pe_word_valid_i = 1'b1;
    pe_word_i       = 15'h1234;
    @(negedge clk);
    check("t2_ready_gap0", {31'h0, pe_word_ready_o}, 32'h0);
    check("t2_busy", {31'h0, tx_busy_o}, 32'h1);
    send_word(15'h1234);
    pe_word_valid_i = 1'b1;
    pe_word_i       = 15'h7FFF;
    @(negedge clk);
    check("t2_ready_gap1", {31'h0, pe_word_ready_o}, 32'h0);
    check("t2_busy_mid", {31'h0, tx_busy_o}, 32'h1);
    send_word(15'h7FFF);
    @(negedge clk);
    check("t2_busy_end", {31'h0, tx_busy_o}, 32'h0);
    tick();

    // 3: router full for 5 cycles during BODY.
    send_hdr(4'h8, 3'd1);
    local_full_i    = 1'b1;
    pe_word_valid_i = 1'b1;
    pe_word_i       = 15'h0ABC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_ready_full", {31'h0, pe_word_ready_o}, 32'h0);
    end
    tick();
    local_full_i = 1'b0;
    @(negedge clk);
    check("t3_ready_after_full", {31'h0, pe_word_ready_o}, 32'h1);
    txq.push_back({2'b10, 15'h0ABC});
    tick();
    pe_word_valid_i = 1'b0;
    @(negedge clk);
    check("t3_launch", {15'h0, local_data_o}, {15'h0, 2'b10, 15'h0ABC});
    tick();

    // 4: fill the RX FIFO, overflow on the 9th flit, then drain in order.
    for (int i = 0; i < 8; i++) begin
      f = {i[0], 15'h0100 + 15'(i)};
      rxq.push_back(f);
      rx_drive(f);
    end
    local_data_i = 17'h0;
    @(negedge clk);
    check("t4_valid_full", {31'h0, rx_valid_o}, 32'h1);
    check("t4_no_overflow", {31'h0, rx_overflow_o}, 32'h0);
    tick();
    rx_drive(16'h7EEE);
    local_data_i = 17'h0;
    @(negedge clk);
    check("t4_overflow", {31'h0, rx_overflow_o}, 32'h1);
    tick();
    rx_pops = 0;
    rx_drain();
    check("t4_pop_count", rx_pops, 32'd8);
    check("t4_rxq_left", rxq.size(), 32'd0);
    check("t4_overflow_sticky", {31'h0, rx_overflow_o}, 32'h1);
    tick();

    // 5: full FIFO with simultaneous push and pop across wrap-around.
    do_reset();
    check("t5_overflow_cleared", {31'h0, rx_overflow_o}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      f = {~i[0], 15'h2000 + 15'(i)};
      rxq.push_back(f);
      rx_drive(f);
    end
    rx_pops    = 0;
    rx_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      f = {i[1], 15'h3000 + 15'(i * 7)};
      rxq.push_back(f);
      rx_drive(f);
    end
    local_data_i = 17'h0;
    rx_ready_i   = 1'b0;
    @(negedge clk);
    check("t5_stream_pops", rx_pops, 32'd20);
    check("t5_no_overflow", {31'h0, rx_overflow_o}, 32'h0);
    check("t5_still_full", rxq.size(), 32'd8);
    tick();
    rx_drain();
    check("t5_total_pops", rx_pops, 32'd28);
    check("t5_rxq_left", rxq.size(), 32'd0);
    tick();

    // 6: asynchronous reset mid-BODY with flits in the RX FIFO.
    rx_drive(16'h8001);
    rx_drive(16'h0002);
    local_data_i = 17'h0;
    send_hdr(4'h2, 3'd3);
    send_word(15'h0456);
    pe_word_valid_i = 1'b1;
    pe_word_i       = 15'h0789;
    #1;
    rst = 1'b0;
    txq.delete();
    rxq.delete();
    #1;
    check("t6_local_data_async", {15'h0, local_data_o}, 32'h0);
    check("t6_rx_valid_async", {31'h0, rx_valid_o}, 32'h0);
    check("t6_busy_async", {31'h0, tx_busy_o}, 32'h0);
    check("t6_ready_async", {31'h0, pe_word_ready_o}, 32'h0);
    pe_word_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    send_hdr(4'h5, 3'd1);
    send_word(15'h5555);
    repeat (4) tick();
    check("end_txq_left", txq.size(), 32'd0);
    check("end_rxq_left", rxq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/network_interface.md
Name: network_interface

Overview:
- Per-node network interface: the far end of a router's local port.
- TX side: packetises processing-element (PE) requests into 17-bit header/body flits and drives them onto the router's local input, throttled by the router's local_full indication.
- RX side: accepts every flit the router delivers on its local output, buffers it in a FIFO and hands it to the PE with a valid/ready handshake.
- One instance sits beside each router_N in the 4x4 mesh.

Parameters:
- NODE_ID, 15, this node's 4-bit router ID; placed in the src field of every header flit.
- RX_DEPTH, 8, RX FIFO depth in flits; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pe_req_i  in  1  PE requests a new packet.
- pe_dest_i  in  4  destination router ID.
- pe_len_i  in  3  number of body flits, 0..7.
- pe_req_ack_o  out  1  header accepted this cycle; combinational.
- pe_word_valid_i  in  1  body word available.
- pe_word_i  in  15  body payload.
- pe_word_ready_o  out  1  body word accepted this cycle; combinational.
- tx_busy_o  out  1  packet in progress; high whenever state is BODY.
- local_data_o  out  17  flit to the router's local_data_i; registered.
- local_full_i  in  1  from the router's local_full_o.
- local_data_i  in  17  flit from the router's local_data_o.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_head_o  out  1  FIFO head flit is a header.
- rx_data_o  out  15  FIFO head flit bits [14:0].
- rx_ready_i  in  1  PE pops the FIFO head.
- rx_overflow_o  out  1  sticky flag: a flit was dropped.

Behaviour:

Flit format:
- Bit 16 = valid.
- Bit 15 = header flag.
- Header flit: [14:11] dest, [10:7] NODE_ID, [6:4] len, [3:0] = 0.
- Body flit: [15] = 0, [14:0] = payload.
- Idle output is 17'b0.

Reset (rst = 0, asynchronous):
- State IDLE, local_data_o = 0, RX FIFO empty, rx_overflow_o = 0.
- All combinational outputs 0.
- A packet in flight is truncated; reset is always system-wide.

Launch rule:
- A flit may launch at edge t only if local_full_i = 0 at t and no flit launched at edge t-1.
- The mandatory gap covers the router's one-cycle credit update latency.
- A launched flit drives local_data_o[16] = 1 for exactly one cycle.
- local_data_o returns to 0 in every other cycle.

TX state machine:
- IDLE:
  - pe_req_ack_o = pe_req_i & launch_ok.
  - On ack: register the header onto local_data_o (visible the cycle after ack) and load remaining = pe_len_i.
  - If pe_len_i = 0, stay in IDLE; otherwise go to BODY.
- BODY:
  - pe_word_ready_o = launch_ok; pe_req_ack_o = 0.
  - On pe_word_valid_i & pe_word_ready_o: launch a body flit with pe_word_i and decrement remaining.
  - When remaining reaches 0, go to IDLE.
  - PE stalls (pe_word_valid_i = 0) are allowed indefinitely; no timeout.
- Latency: handshake cycle to flit on local_data_o is 1 cycle.
- Peak rate: one flit per 2 cycles.
- dest = NODE_ID is legal and is not special-cased.

RX path:
- Every edge with local_data_i[16] = 1 pushes {[15], [14:0]}. There is no back-pressure to the router.
- Pop occurs on rx_valid_o & rx_ready_i.
- FIFO full and a push arrives:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the flit is dropped and rx_overflow_o is set; it stays set until reset.
- Empty FIFO: rx_valid_o = 0, and rx_ready_i is ignored.
- Occupancy counter is log2(RX_DEPTH)+1 bits wide.
- Read and write pointers wrap modulo RX_DEPTH.
- rx_data_o and rx_head_o are driven directly from the FIFO head; 0 when empty.
- The TX and RX paths are fully independent.

Test Plan:
1. Reset, then pe_req_i = 1, dest = 4'h3, len = 0, local_full_i = 0:
   - ack in cycle 1;
   - local_data_o = {1,1,4'h3,4'hF,3'd0,4'h0} in cycle 2, then 0;
   - tx_busy_o stays 0.
2. len = 2, words 15'h1234 and 15'h7FFF offered every cycle:
   - header, gap, body 0x1234, gap, body 0x7FFF on alternating cycles;
   - pe_word_ready_o toggles;
   - tx_busy_o falls after the last body flit.
3. local_full_i = 1 for 5 cycles during BODY:
   - no flits and pe_word_ready_o = 0 throughout;
   - the flit launches on the first edge after full drops, provided the gap rule is met.
4. Push 8 flits with rx_ready_i = 0:
   - rx_valid_o = 1 and rx_overflow_o = 0.
   - 9th flit is dropped and rx_overflow_o = 1.
   - Draining then yields the first 8 flits in order with the correct rx_head_o.
5. FIFO full, simultaneous push and pop:
   - no drop and count stays 8;
   - wrap-around order is preserved across 20 flits.
6. Assert rst mid-BODY:
   - local_data_o = 0 and the FIFO empties immediately, without waiting for a clock edge;
   - after release, a new request is acked normally.
